// File: rtl/diamond_pkg.sv
// Shared token-type and FSM state definitions for the number-diamond generator.
// Build option DIAMOND_LOWER_HALF_EN selects full diamond vs pyramid in the importers.
package diamond_pkg;

  typedef enum logic [1:0] {
    TOK_PAD = 2'd0,
    TOK_NUM = 2'd1,
    TOK_EOL = 2'd2
  } tok_type_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PAD,
    ST_NUM,
    ST_EOL,
    ST_FIN
  } state_t;

endpackage

// File: rtl/diamond_row_ctr.sv
// Row index / direction / in-row column counter for the diamond generator.
// DIAMOND_LOWER_HALF_EN adds the descending half; otherwise rows only count up.
module diamond_row_ctr
  import diamond_pkg::*;
#(
  parameter int unsigned DW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          col_inc,
  input  logic          col_clr,
  input  logic          row_adv,
  input  logic [DW-1:0] n,
  output logic [DW-1:0] row,
  output logic [DW-1:0] row_next,
  output logic          pad_last,
  output logic          num_last,
  output logic          pat_last,
  output logic          next_pad
);

  localparam logic [DW-1:0] ONE = DW'(1);

  logic [DW-1:0] col;

`ifdef DIAMOND_LOWER_HALF_EN
  logic down;
  logic turn;

  // Once the peak row n is reached, every following row steps down.
  assign turn     = down || (row == n);
  assign row_next = turn ? row - ONE : row + ONE;
  assign pat_last = (row == ONE) && turn;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       down <= 1'b0;
    else if (load)    down <= 1'b0;
    else if (row_adv) down <= turn;
  end
`else
  assign row_next = row + ONE;
  assign pat_last = (row == n);
`endif

  assign next_pad = (row_next != n);
  assign pad_last = (col == n - row - ONE);
  assign num_last = (col == row - ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
    end else if (load) begin
      row <= ONE;
      col <= '0;
    end else if (row_adv) begin
      row <= row_next;
      col <= '0;
    end else if (col_clr) begin
      col <= '0;
    end else if (col_inc) begin
      col <= col + ONE;
    end
  end

endmodule

// File: rtl/diamond_pattern_gen.sv
// Number-diamond token stream generator: PAD/NUM/EOL tokens over valid/ready.
// Define DIAMOND_LOWER_HALF_EN for the full diamond; default build emits the pyramid only.
module diamond_pattern_gen
  import diamond_pkg::*;
#(
  parameter int unsigned MAX_N = 15,
  parameter int unsigned DW    = $clog2(MAX_N + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic [DW-1:0] n_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          tok_valid_o,
  input  logic          tok_ready_i,
  output logic [1:0]    tok_type_o,
  output logic [DW-1:0] tok_val_o,
  output logic [DW-1:0] row_o
);

  localparam logic [DW-1:0] N_MAX = DW'(MAX_N);
  localparam logic [DW-1:0] ONE   = DW'(1);

  state_t        state;
  logic [DW-1:0] n_r;
  logic [DW-1:0] n_sat;
  logic          hs;
  logic          load;
  logic          col_inc;
  logic          col_clr;
  logic          row_adv;
  logic [DW-1:0] row;
  logic [DW-1:0] row_next;
  logic          pad_last;
  logic          num_last;
  logic          pat_last;
  logic          next_pad;

  assign n_sat   = (n_i > N_MAX) ? N_MAX : n_i;
  assign hs      = tok_valid_o && tok_ready_i;
  assign load    = (state == ST_IDLE) && start_i;
  assign col_inc = hs && (((state == ST_PAD) && !pad_last) || ((state == ST_NUM) && !num_last));
  assign col_clr = hs && (((state == ST_PAD) && pad_last) || ((state == ST_NUM) && num_last));
  assign row_adv = hs && (state == ST_EOL) && !pat_last;
  assign row_o   = row;

  diamond_row_ctr #(.DW(DW)) u_row_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .col_inc  (col_inc),
    .col_clr  (col_clr),
    .row_adv  (row_adv),
    .n        (n_r),
    .row      (row),
    .row_next (row_next),
    .pad_last (pad_last),
    .num_last (num_last),
    .pat_last (pat_last),
    .next_pad (next_pad)
  );

  // The output register always holds the token currently offered; each handshake loads the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      n_r         <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      tok_valid_o <= 1'b0;
      tok_type_o  <= TOK_PAD;
      tok_val_o   <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            n_r <= n_sat;
            if (n_sat == '0) begin
              state  <= ST_FIN;
              done_o <= 1'b1;
            end else begin
              busy_o      <= 1'b1;
              tok_valid_o <= 1'b1;
              if (n_sat == ONE) begin
                state      <= ST_NUM;
                tok_type_o <= TOK_NUM;
                tok_val_o  <= ONE;
              end else begin
                state      <= ST_PAD;
                tok_type_o <= TOK_PAD;
                tok_val_o  <= '0;
              end
            end
          end
        end
        ST_PAD: begin
          if (hs && pad_last) begin
            state      <= ST_NUM;
            tok_type_o <= TOK_NUM;
            tok_val_o  <= row;
          end
        end
        ST_NUM: begin
          if (hs && num_last) begin
            state      <= ST_EOL;
            tok_type_o <= TOK_EOL;
            tok_val_o  <= '0;
          end
        end
        ST_EOL: begin
          if (hs) begin
            if (pat_last) begin
              state       <= ST_FIN;
              busy_o      <= 1'b0;
              done_o      <= 1'b1;
              tok_valid_o <= 1'b0;
              tok_type_o  <= TOK_PAD;
              tok_val_o   <= '0;
            end else if (next_pad) begin
              state      <= ST_PAD;
              tok_type_o <= TOK_PAD;
              tok_val_o  <= '0;
            end else begin
              state      <= ST_NUM;
              tok_type_o <= TOK_NUM;
              tok_val_o  <= row_next;
            end
          end
        end
        ST_FIN: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_diamond_pattern_gen.sv
// Self-checking bench for diamond_pattern_gen against a row-list reference model.
// Follows the DUT build: DIAMOND_LOWER_HALF_EN selects the diamond model.
module tb_diamond_pattern_gen;

  localparam int unsigned MAX_N = 15;
  localparam int unsigned DW    = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic [DW-1:0] n_i = '0;
  logic          tok_ready_i = 1'b0;
  logic          busy_o;
  logic          done_o;
  logic          tok_valid_o;
  logic [1:0]    tok_type_o;
  logic [DW-1:0] tok_val_o;
  logic [DW-1:0] row_o;

  typedef struct packed {
    logic [1:0]    typ;
    logic [DW-1:0] val;
    logic [DW-1:0] row;
  } tok_t;

  tok_t        exp_q[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  diamond_pattern_gen #(.MAX_N(MAX_N), .DW(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .n_i         (n_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .tok_valid_o (tok_valid_o),
    .tok_ready_i (tok_ready_i),
    .tok_type_o  (tok_type_o),
    .tok_val_o   (tok_val_o),
    .row_o       (row_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: list the rows, then expand each into (n-i) PAD, i NUM(i), one EOL.
  task automatic build_model(input int n);
    int   rows[$];
    tok_t t;
    exp_q.delete();
    for (int r = 1; r <= n; r++) rows.push_back(r);
`ifdef DIAMOND_LOWER_HALF_EN
    for (int r = n - 1; r >= 1; r--) rows.push_back(r);
`endif
    foreach (rows[k]) begin
      for (int p = 0; p < n - rows[k]; p++) begin
        t.typ = 2'd0; t.val = '0; t.row = DW'(rows[k]);
        exp_q.push_back(t);
      end
      for (int p = 0; p < rows[k]; p++) begin
        t.typ = 2'd1; t.val = DW'(rows[k]); t.row = DW'(rows[k]);
        exp_q.push_back(t);
      end
      t.typ = 2'd2; t.val = '0; t.row = DW'(rows[k]);
      exp_q.push_back(t);
    end
  endtask

  task automatic run(input int n_req, input int unsigned ready_pct, input bit poke);
    int   n_eff;
    int   total;
    int   cyc;
    int   first_valid;
    int   done_cyc;
    int   accepted;
    bit   held;
    bit   rdy;
    tok_t prev;
    tok_t cur;
    tok_t e;
    n_eff = (n_req > int'(MAX_N)) ? int'(MAX_N) : n_req;
    build_model(n_eff);
    total = exp_q.size();
    first_valid = 0; done_cyc = 0; accepted = 0; held = 1'b0; prev = '0;

    @(posedge clk); #1;
    start_i = 1'b1; n_i = DW'(n_req);
    @(posedge clk); #1;
    start_i = 1'b0;
    cyc = 1;
    while (done_cyc == 0 && cyc < 4000) begin
      n_i = DW'($urandom_range(31));
      start_i = poke && (accepted == 5);
      cur = {tok_type_o, tok_val_o, row_o};
      if (tok_valid_o) begin
        if (first_valid == 0) first_valid = cyc;
        if (held) check("stall_hold", {31'd0, 1'b1} << 12 | 32'(cur), {31'd0, 1'b1} << 12 | 32'(prev));
        rdy = ($urandom_range(99) < ready_pct);
        tok_ready_i = rdy;
        if (rdy) begin
          check("busy_during_stream", 32'(busy_o), 32'd1);
          if (exp_q.size() == 0) begin
            check("extra_token", 32'(accepted), 32'(total));
          end else begin
            e = exp_q.pop_front();
            check("token", 32'(cur), 32'(e));
          end
          accepted++;
          held = 1'b0;
        end else begin
          held = 1'b1;
          prev = cur;
        end
      end else begin
        tok_ready_i = 1'($urandom_range(1));
      end
      if (done_o) done_cyc = cyc;
      else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    start_i = 1'b0;
    tok_ready_i = 1'b0;
    if (done_cyc == 0) begin
      check("done_timeout", 32'd0, 32'd1);
    end else begin
      check("done_busy_low", 32'(busy_o), 32'd0);
      check("done_valid_low", 32'(tok_valid_o), 32'd0);
      check("token_count", 32'(accepted), 32'(total));
      if (total > 0) check("first_valid_cycle", 32'(first_valid), 32'd1);
      else check("n0_no_valid", 32'(first_valid), 32'd0);
      if (ready_pct >= 100) check("done_cycle", 32'(done_cyc), 32'(total + 1));
    end
  endtask

  initial begin
    #12;
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_valid", 32'(tok_valid_o), 32'd0);
    check("rst_tok", 32'({tok_type_o, tok_val_o, row_o}), 32'd0);
    rst_n = 1'b1;

    run(5, 100, 1'b0);
    run(1, 100, 1'b0);
    run(0, 100, 1'b0);
    run(3, 50, 1'b0);
    run(20, 70, 1'b1);

    // Asynchronous reset partway through a stream.
    @(posedge clk); #1;
    start_i = 1'b1; n_i = DW'(4); tok_ready_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("pre_rst_busy", 32'(busy_o), 32'd1);
    check("pre_rst_valid", 32'(tok_valid_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", 32'(busy_o), 32'd0);
    check("async_rst_valid", 32'(tok_valid_o), 32'd0);
    check("async_rst_tok", 32'({done_o, tok_type_o, tok_val_o, row_o}), 32'd0);
    tok_ready_i = 1'b0;
    #3 rst_n = 1'b1;
    run(2, 100, 1'b0);

    repeat (4) run(int'($urandom_range(17)), $urandom_range(30, 100), 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
